audio_i2s_ctrl: RTL and testbench

Sequences the core's I2S audio output path. It generates MCLK from clk_74a with a fractional accumulator and derives SCLK and LRCK internally. It buffers stereo 16-bit samples from the core through a valid/ready FIFO and serialises one sample pair per 48 kHz frame. It replaces the free-running silence generator at core_top and drives audio_mclk, audio_lrck and audio_dac directly.

---
 rtl/audio_pkg.sv | 28 ++
 rtl/audio_sample_fifo.sv | 44 ++++
 rtl/audio_i2s_ctrl.sv | 116 +++++++++++
 tb/tb_audio_i2s_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio output path.
package audio_pkg;

  localparam int unsigned ACCUM_STEP_48K  = 245760;
  localparam int unsigned ACCUM_MOD_74M25 = 742500;
  localparam int unsigned SAMPLE_W        = 16;
  localparam int unsigned SLOT_BITS       = 32;
  localparam int unsigned FRAME_BITS      = 64;
  localparam int unsigned ACCUM_W         = 22;
  localparam int unsigned BITCNT_W        = $clog2(FRAME_BITS);

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } sample_pair_t;

  // Serial bit for frame position p, including the one-SCLK I2S delay after each LRCK edge.
  function automatic logic serial_bit(input sample_pair_t pair, input logic [BITCNT_W-1:0] p);
    int unsigned pi;
    pi = p;
    serial_bit = 1'b0;
    if (pi >= 1 && pi <= 16)
      serial_bit = pair.l[4'(16 - pi)];
    else if (pi >= 33 && pi <= 48)
      serial_bit = pair.r[4'(48 - pi)];
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous FIFO holding stereo sample pairs; dout shows the head entry.
module audio_sample_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_74a,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_74a) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/audio_i2s_ctrl.sv
// I2S output sequencer: fractional MCLK generator, SCLK/LRCK framing and sample serialiser.
module audio_i2s_ctrl
  import audio_pkg::*;
#(
  parameter int unsigned ACCUM_STEP = ACCUM_STEP_48K,
  parameter int unsigned ACCUM_MOD  = ACCUM_MOD_74M25,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk_74a,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                mute,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_dac,
  output logic                frame_strobe,
  output logic [15:0]         underflow_cnt
);

  localparam logic [ACCUM_W-1:0] STEP = ACCUM_W'(ACCUM_STEP);
  localparam logic [ACCUM_W-1:0] MOD  = ACCUM_W'(ACCUM_MOD);

  logic [ACCUM_W-1:0]  accum;
  logic [ACCUM_W-1:0]  accum_sum;
  logic                wrap;
  logic                mclk_rise;
  logic [1:0]          sclk_div;
  logic                sclk_fall_evt;
  logic [BITCNT_W-1:0] bitcnt;
  logic [BITCNT_W-1:0] bitcnt_next;
  logic                frame_start;
  logic                primed;
  sample_pair_t        frame_reg;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  sample_pair_t        fifo_din;
  sample_pair_t        fifo_dout;

  always_comb begin
    accum_sum     = accum + STEP;
    wrap          = (accum_sum >= MOD);
    mclk_rise     = wrap && !audio_mclk;
    sclk_fall_evt = mclk_rise && (sclk_div == 2'd3);
    bitcnt_next   = bitcnt + 1'b1;
    frame_start   = sclk_fall_evt && (bitcnt_next == '0);
  end

  assign sample_ready = !fifo_full;
  assign fifo_push    = sample_valid && !fifo_full;
  assign fifo_pop     = frame_start && !fifo_empty;
  assign fifo_din     = {sample_l, sample_r};

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * SAMPLE_W)
  ) u_fifo (
    .clk_74a (clk_74a),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (fifo_din),
    .full    (fifo_full),
    .pop     (fifo_pop),
    .empty   (fifo_empty),
    .dout    (fifo_dout)
  );

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      accum         <= '0;
      audio_mclk    <= 1'b0;
      sclk_div      <= '0;
      bitcnt        <= '1;
      audio_lrck    <= 1'b1;
      audio_dac     <= 1'b0;
      frame_strobe  <= 1'b0;
      frame_reg     <= '0;
      primed        <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      frame_strobe <= frame_start;

      if (wrap) begin
        accum      <= accum_sum - MOD;
        audio_mclk <= !audio_mclk;
      end else begin
        accum <= accum_sum;
      end

      if (mclk_rise)
        sclk_div <= sclk_div + 2'd1;

      if (fifo_push)
        primed <= 1'b1;

      // The old frame_reg is still shifted out here; at frame start p=0 yields 0 anyway.
      if (sclk_fall_evt) begin
        bitcnt     <= bitcnt_next;
        audio_lrck <= bitcnt_next[BITCNT_W-1];
        audio_dac  <= serial_bit(frame_reg, bitcnt_next);
      end

      if (frame_start) begin
        frame_reg <= (fifo_empty || mute) ? '0 : fifo_dout;
        if (fifo_empty && primed && (underflow_cnt != '1))
          underflow_cnt <= underflow_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_ctrl.sv
// Bench for audio_i2s_ctrl: behavioural frame/FIFO model checked every cycle plus directed literal checks.
module tb_audio_i2s_ctrl;

  localparam longint STEP  = 245760;
  localparam longint MOD   = 742500;
  localparam int     DEPTH = 4;

  logic        clk_74a = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b0;
  logic        sample_ready;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_dac;
  logic        frame_strobe;
  logic [15:0] underflow_cnt;

  int vectors = 0;
  int miscompares = 0;

  audio_i2s_ctrl #(
    .ACCUM_STEP (245760),
    .ACCUM_MOD  (742500),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_74a       (clk_74a),
    .reset_n       (reset_n),
    .sample_l      (sample_l),
    .sample_r      (sample_r),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .mute          (mute),
    .audio_mclk    (audio_mclk),
    .audio_lrck    (audio_lrck),
    .audio_dac     (audio_dac),
    .frame_strobe  (frame_strobe),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk_74a = ~clk_74a;

  // ---------------- behavioural model ----------------
  longint      m_n;
  int          m_ev;
  int          m_bit;
  logic        m_mclk, m_lrck, m_dac, m_strobe, m_evt;
  logic [31:0] m_q[$];
  logic [31:0] m_cur;
  bit          m_primed;
  int          m_ucnt;

  // Bit heard at frame position p: left slot MSB-first from p=1, right slot from p=33.
  function automatic logic slot_bit(input logic [31:0] pair, input int p);
    logic [31:0] sh;
    if (p >= 1 && p <= 16)       sh = pair >> (31 - (p - 1));
    else if (p >= 33 && p <= 48) sh = pair >> (15 - (p - 33));
    else                         sh = '0;
    return sh[0];
  endfunction

  always @(posedge clk_74a or negedge reset_n) begin : model
    longint w;
    int     ev;
    bit     push_ok, fs;
    if (!reset_n) begin
      m_n = 0; m_ev = 0; m_bit = 63;
      m_mclk = 0; m_lrck = 1; m_dac = 0; m_strobe = 0; m_evt = 0;
      m_q.delete(); m_cur = '0; m_primed = 0; m_ucnt = 0;
    end else begin
      push_ok = sample_valid && (m_q.size() < DEPTH);
      m_n++;
      w      = m_n * STEP / MOD;          // MCLK toggles so far
      m_mclk = w[0];
      ev     = int'((w + 1) / 2 / 4);     // one SCLK falling event per 4 MCLK rises
      m_evt  = (ev != m_ev);
      m_ev   = ev;
      m_bit  = (63 + ev) % 64;
      m_lrck = (m_bit >= 32);
      fs     = m_evt && (m_bit == 0);
      m_strobe = fs;
      if (fs) begin
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          if (mute) m_cur = '0;
        end else begin
          m_cur = '0;
          if (m_primed && m_ucnt < 65535) m_ucnt++;
        end
      end
      if (m_evt) m_dac = slot_bit(m_cur, m_bit);
      if (push_ok) begin
        m_q.push_back({sample_l, sample_r});
        m_primed = 1;
      end
    end
  end

  // ---------------- compare + monitors ----------------
  int          toggles = 0, rises = 0, strobes = 0;
  int          lrck_period = 0, rise_at_lrck = 0;
  logic        prev_mclk = 1'b0, prev_lrck = 1'b1;
  logic [63:0] cap_w = '0;
  logic [63:0] caps[$];

  always @(posedge clk_74a) begin
    logic [20:0] act, exp;
    #1;
    act = {audio_mclk, audio_lrck, audio_dac, frame_strobe, sample_ready, underflow_cnt};
    exp = {m_mclk, m_lrck, m_dac, m_strobe, (m_q.size() < DEPTH), m_ucnt[15:0]};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cycle t=%0t {mclk,lrck,dac,strobe,ready,ucnt} got %h expected %h", $time, act, exp);
    end
    if (audio_mclk != prev_mclk) toggles++;
    if (audio_mclk && !prev_mclk) rises++;
    if (audio_lrck && !prev_lrck) begin
      lrck_period  = rises - rise_at_lrck;
      rise_at_lrck = rises;
    end
    if (frame_strobe) strobes++;
    prev_mclk = audio_mclk;
    prev_lrck = audio_lrck;
    if (m_evt && reset_n) begin
      cap_w[63 - m_bit] = audio_dac;
      if (m_bit == 63) caps.push_back(cap_w);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge clk_74a);
  endtask

  task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_strobes(input int k);
    int target;
    int t;
    target = strobes + k;
    t = 0;
    while (strobes < target && t < 2000 * k) begin
      @(negedge clk_74a);
      t++;
    end
    if (strobes < target) expect_eq("strobe_timeout", strobes, target);
  endtask

  // Called at a negedge; leaves sample_valid high so pushes can run back-to-back.
  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int t;
    sample_l = l; sample_r = r; sample_valid = 1'b1;
    t = 0;
    while (!sample_ready && t < 4000) begin
      @(negedge clk_74a);
      t++;
    end
    if (!sample_ready) expect_eq("push_timeout", sample_ready, 1);
    @(negedge clk_74a);
  endtask

  task automatic do_reset();
    @(negedge clk_74a);
    reset_n = 1'b0; sample_valid = 1'b0; mute = 1'b0;
    tick(3);
    reset_n = 1'b1;
  endtask

  function automatic logic [63:0] frame_word(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 16'h0000, r, 15'h0000};
  endfunction

  logic [15:0] pl[5] = '{16'h1234, 16'h8001, 16'hFFFF, 16'h0002, 16'h5A5A};
  logic [15:0] pr[5] = '{16'hCAFE, 16'h7FFE, 16'h0000, 16'h4000, 16'hA5A5};

  initial begin
    int t0, sc, nz, r0, t, perm;
    bit acc_prev;

    // reset state
    tick(2);
    expect_eq("reset_state", {audio_mclk, audio_lrck, audio_dac, frame_strobe, sample_ready, underflow_cnt},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000});
    tick(1);
    reset_n = 1'b1;

    // free-run with no samples
    t0 = toggles;
    tick(12000);
    vectors++;
    if (toggles - t0 < 3970 || toggles - t0 > 3972) begin
      miscompares++;
      $display("FAIL mclk_toggles: got %0d expected 3971 +/-1", toggles - t0);
    end
    expect_eq("lrck_period", lrck_period, 256);
    expect_eq("idle_ucnt", underflow_cnt, 0);
    nz = 0;
    foreach (caps[i]) if (caps[i] != '0) nz++;
    expect_eq("idle_silence", nz, 0);
    expect_eq("idle_frames_seen", caps.size() >= 6, 1);

    // single pair serialisation
    wait_strobes(1); tick(10);
    push(16'hA5C3, 16'h0F01); sample_valid = 1'b0;
    wait_strobes(2);
    expect_eq("frame_A5C3_0F01", caps[caps.size()-1], 64'h52E1_8000_0780_8000);
    expect_eq("frame_word_fn", frame_word(16'hA5C3, 16'h0F01), 64'h52E1_8000_0780_8000);

    // five back-to-back pushes: backpressure and ordering
    wait_strobes(1); tick(10);
    for (int i = 0; i < 4; i++) push(pl[i], pr[i]);
    expect_eq("ready_after_4", sample_ready, 0);
    sc = strobes;
    push(pl[4], pr[4]); sample_valid = 1'b0;
    expect_eq("fifth_after_pop", strobes - sc, 1);
    wait_strobes(5);
    for (int i = 0; i < 5; i++)
      expect_eq($sformatf("order_%0d", i), caps[caps.size()-5+i], frame_word(pl[i], pr[i]));

    // starvation count after one pair
    do_reset();
    wait_strobes(1); tick(10);
    push(16'h7FFF, 16'h8000); sample_valid = 1'b0;
    wait_strobes(4);
    expect_eq("starve_ucnt", underflow_cnt, 3);
    expect_eq("starve_silent", caps[caps.size()-1], 64'h0);
    expect_eq("starve_played", caps[caps.size()-3], frame_word(16'h7FFF, 16'h8000));

    // mute drains queued pairs silently
    tick(10);
    push(16'h1111, 16'h2222); push(16'h3333, 16'h4444); sample_valid = 1'b0;
    mute = 1'b1;
    wait_strobes(2);
    mute = 1'b0;
    push(16'h6789, 16'hABCD); sample_valid = 1'b0;
    wait_strobes(2);
    expect_eq("mute_frame1", caps[caps.size()-3], 64'h0);
    expect_eq("mute_frame2", caps[caps.size()-2], 64'h0);
    expect_eq("unmute_frame", caps[caps.size()-1], frame_word(16'h6789, 16'hABCD));
    expect_eq("mute_ucnt", underflow_cnt, 4);

    // asynchronous reset mid-frame with queued pairs
    tick(10);
    push(16'h0101, 16'h0202); push(16'h0303, 16'h0404); push(16'h0505, 16'h0606);
    sample_valid = 1'b0;
    t = 0;
    while (m_bit != 20 && t < 4000) begin tick(1); t++; end
    expect_eq("reach_bit20", (m_bit == 20), 1);
    reset_n = 1'b0;
    #1;
    expect_eq("reset_async", {audio_mclk, audio_lrck, audio_dac, frame_strobe, sample_ready, underflow_cnt},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000});
    r0 = rises;
    tick(2);
    reset_n = 1'b1;
    wait_strobes(1);
    expect_eq("first_strobe_rises", rises - r0, 4);
    wait_strobes(1);
    expect_eq("post_reset_silent", caps[caps.size()-1], 64'h0);
    expect_eq("post_reset_ucnt", underflow_cnt, 0);

    // randomized traffic and mute
    acc_prev = 1'b0;
    for (int b = 0; b < 6; b++) begin
      perm = $urandom_range(0, 4);
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk_74a);
        if (!sample_valid || acc_prev) begin
          sample_valid = ($urandom_range(0, 999) < perm);
          sample_l = 16'($urandom);
          sample_r = 16'($urandom);
        end
        acc_prev = sample_valid && sample_ready;
        if ($urandom_range(0, 1999) == 0) mute = ~mute;
      end
    end
    sample_valid = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
